chop_demod: RTL and testbench

Synchronous demodulator for chopped ADC data: the receiving end of the chopper generator. It takes the chop phase and data-hold strobe that travel with the ADC sample stream, discards samples taken during hold (settling) windows, and sign-accumulates the rest. Once per full chop period it emits the demodulated sum (positive half minus negative half), the offset sum, and the per-half sample counts. It sits between the ADC word-sync capture and the interlock threshold logic in the W7-X interlock FP design.

---
 rtl/chop_demod_pkg.sv | 20 ++
 rtl/chop_demod_if.sv | 34 +++
 rtl/chop_acc.sv | 35 +++
 rtl/chop_demod.sv | 117 +++++++++++
 tb/tb_chop_demod.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/chop_demod_pkg.sv
// Shared state encoding and default widths for the chop demodulator.
package chop_demod_pkg;

  localparam int ADC_W_DEF = 18;
  localparam int CNT_W_DEF = 16;
  localparam int ACC_W_DEF = 40;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_ACC_POS = 2'd2,
    ST_ACC_NEG = 2'd3
  } state_e;

  // True in the two accumulating states (i.e. while locked to the chop phase).
  function automatic logic is_acc(input state_e s);
    return (s == ST_ACC_POS) || (s == ST_ACC_NEG);
  endfunction

endpackage

// File: rtl/chop_demod_if.sv
// Sample-stream input and period-result output bundle of the chop demodulator.
interface chop_demod_if
  import chop_demod_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) ();

  logic                    demod_en;
  logic signed [ADC_W-1:0] adc_data_i;
  logic                    adc_valid_i;
  logic                    chop_i;
  logic                    data_hold_i;

  logic signed [ACC_W-1:0] demod_o;
  logic signed [ACC_W-1:0] offset_o;
  logic [CNT_W-1:0]        n_pos_o;
  logic [CNT_W-1:0]        n_neg_o;
  logic                    valid_o;
  logic                    ovf_o;
  logic                    locked_o;

  modport master (
    output demod_en, adc_data_i, adc_valid_i, chop_i, data_hold_i,
    input  demod_o, offset_o, n_pos_o, n_neg_o, valid_o, ovf_o, locked_o
  );

  modport slave (
    input  demod_en, adc_data_i, adc_valid_i, chop_i, data_hold_i,
    output demod_o, offset_o, n_pos_o, n_neg_o, valid_o, ovf_o, locked_o
  );

endinterface

// File: rtl/chop_acc.sv
// One half-period accumulator: signed running sum plus saturating sample count.
// clr wins over load; load restarts the half with only this cycle's sample.
module chop_acc #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    add,
  input  logic signed [ACC_W-1:0] sample,
  output logic signed [ACC_W-1:0] sum,
  output logic [CNT_W-1:0]        cnt,
  output logic                    sat
);

  // A full counter refuses further samples; the caller flags the drop.
  assign sat = &cnt;

  // Sum/count update: clear, restart-with-sample, or accumulate if not saturated.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sum <= '0;
      cnt <= '0;
    end else if (load) begin
      sum <= add ? sample : '0;
      cnt <= add ? CNT_W'(1) : '0;
    end else if (add && !sat) begin
      sum <= sum + sample;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chop_demod.sv
// Chopped-ADC synchronous demodulator: locks to the chop phase, drops hold
// samples, sign-accumulates each half and reports pos-neg / pos+neg per period.
module chop_demod
  import chop_demod_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  chop_demod_if.slave bus
);

  state_e state, state_nxt;
  logic   chop_q;
  logic   en, fall, rise, acc_st, accept, close, clr;
  logic   add_pos, add_neg, load_pos, load_neg;
  logic   sat_pos, sat_neg;

  logic signed [ACC_W-1:0] smp;
  logic signed [ACC_W-1:0] sum_pos, sum_neg;
  logic [CNT_W-1:0]        cnt_pos, cnt_neg;

  logic signed [ACC_W-1:0] demod_q, offset_q;
  logic [CNT_W-1:0]        n_pos_q, n_neg_q;
  logic                    valid_q, ovf_q;

  assign en     = bus.demod_en;
  assign fall   = chop_q & ~bus.chop_i;
  assign rise   = ~chop_q & bus.chop_i;
  assign acc_st = is_acc(state);
  assign smp    = {{(ACC_W-ADC_W){bus.adc_data_i[ADC_W-1]}}, bus.adc_data_i};

  // Sign follows this cycle's chop, so an edge-cycle sample joins the new half.
  assign accept   = en & acc_st & bus.adc_valid_i & ~bus.data_hold_i;
  assign add_pos  = accept & ~bus.chop_i;
  assign add_neg  = accept & bus.chop_i;
  // Falling edge restarts the positive half; negative half restarts on either edge
  // (rise: first sample of the half, fall: emptied after the period closes).
  assign load_pos = acc_st & fall;
  assign load_neg = acc_st & (rise | fall);
  // Hold both halves empty until locked, and whenever disabled.
  assign clr      = ~en | ~acc_st;
  // Period closes on the falling edge in the negative half; disable suppresses it.
  assign close    = en & (state == ST_ACC_NEG) & fall;

  chop_acc #(.CNT_W(CNT_W), .ACC_W(ACC_W)) u_acc_pos (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load_pos), .add(add_pos),
    .sample(smp), .sum(sum_pos), .cnt(cnt_pos), .sat(sat_pos)
  );

  chop_acc #(.CNT_W(CNT_W), .ACC_W(ACC_W)) u_acc_neg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load_neg), .add(add_neg),
    .sample(smp), .sum(sum_neg), .cnt(cnt_neg), .sat(sat_neg)
  );

  // State register and chop delay used for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      chop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      chop_q <= bus.chop_i;
    end
  end

  // Next state: wait for a falling edge to lock, then alternate halves on edges.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (en)   state_nxt = ST_SYNC;
      ST_SYNC:    if (fall) state_nxt = ST_ACC_POS;
      ST_ACC_POS: if (rise) state_nxt = ST_ACC_NEG;
      ST_ACC_NEG: if (fall) state_nxt = ST_ACC_POS;
      default:              state_nxt = ST_IDLE;
    endcase
    if (!en) state_nxt = ST_IDLE;
  end

  // Sticky flag for a sample dropped at a full counter; a restart load never drops.
  always_ff @(posedge clk) begin
    if (!rst_n || !en)
      ovf_q <= 1'b0;
    else if ((add_pos & sat_pos & ~load_pos) | (add_neg & sat_neg & ~load_neg))
      ovf_q <= 1'b1;
  end

  // Period results from the totals held before the closing cycle's sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      demod_q  <= '0;
      offset_q <= '0;
      n_pos_q  <= '0;
      n_neg_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= close;
      if (close) begin
        demod_q  <= sum_pos - sum_neg;
        offset_q <= sum_pos + sum_neg;
        n_pos_q  <= cnt_pos;
        n_neg_q  <= cnt_neg;
      end
    end
  end

  assign bus.demod_o  = demod_q;
  assign bus.offset_o = offset_q;
  assign bus.n_pos_o  = n_pos_q;
  assign bus.n_neg_o  = n_neg_q;
  assign bus.valid_o  = valid_q;
  assign bus.ovf_o    = ovf_q;
  assign bus.locked_o = acc_st;

endmodule

// File: tb/tb_chop_demod.sv
// Directed bench: a default-width and a CNT_W=4 demodulator share one stimulus.
`timescale 1ns/1ps
module tb_chop_demod;

  localparam int ADC_W = 18;
  localparam int CNT_W = 16;
  localparam int ACC_W = 40;
  localparam int CNT_S = 4;
  localparam int ACC_S = 24;

  localparam logic signed [ADC_W-1:0] NEG_FS = 18'sh20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #250 clk = ~clk;

  chop_demod_if #(.ADC_W(ADC_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) cd_if ();
  chop_demod_if #(.ADC_W(ADC_W), .CNT_W(CNT_S), .ACC_W(ACC_S)) cd_if_s ();

  chop_demod #(.ADC_W(ADC_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(cd_if)
  );

  chop_demod #(.ADC_W(ADC_W), .CNT_W(CNT_S), .ACC_W(ACC_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(cd_if_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle after each rising edge.
  int   mcyc = 0, vcnt = 0, consec = 0, lock_cyc = -1, first_v = -1, last_v = -1, gap = 0;
  logic v_prev = 1'b0;
  logic signed [ACC_W-1:0] c_demod = '0, c_offset = '0;
  logic [CNT_W-1:0]        c_np = '0, c_nn = '0;
  logic signed [ACC_S-1:0] s_demod = '0, s_offset = '0;
  logic [CNT_S-1:0]        s_np = '0, s_nn = '0;

  always @(posedge clk) begin
    #100;
    mcyc <= mcyc + 1;
    v_prev <= cd_if.valid_o;
    if (cd_if.locked_o && lock_cyc < 0) lock_cyc <= mcyc;
    if (cd_if.valid_o) begin
      if (v_prev) consec <= consec + 1;
      if (first_v < 0) first_v <= mcyc;
      if (last_v >= 0) gap <= mcyc - last_v;
      last_v   <= mcyc;
      vcnt     <= vcnt + 1;
      c_demod  <= cd_if.demod_o;
      c_offset <= cd_if.offset_o;
      c_np     <= cd_if.n_pos_o;
      c_nn     <= cd_if.n_neg_o;
    end
    if (cd_if_s.valid_o) begin
      s_demod  <= cd_if_s.demod_o;
      s_offset <= cd_if_s.offset_o;
      s_np     <= cd_if_s.n_pos_o;
      s_nn     <= cd_if_s.n_neg_o;
    end
  end

  task automatic set_en(input logic e);
    cd_if.demod_en   = e;
    cd_if_s.demod_en = e;
  endtask

  // Drive one sample slot on both DUTs; returns after its rising edge.
  task automatic cyc(input logic signed [ADC_W-1:0] d, input logic v,
                     input logic c, input logic h);
    cd_if.adc_data_i    = d;  cd_if_s.adc_data_i  = d;
    cd_if.adc_valid_i   = v;  cd_if_s.adc_valid_i = v;
    cd_if.chop_i        = c;  cd_if_s.chop_i      = c;
    cd_if.data_hold_i   = h;  cd_if_s.data_hold_i = h;
    @(negedge clk);
  endtask

  // n slots of one chop phase, the first nh of them marked as hold.
  task automatic half(input logic c, input int n, input logic signed [ADC_W-1:0] d,
                      input int nh);
    for (int i = 0; i < n; i++) cyc(d, 1'b1, c, (i < nh));
  endtask

  task automatic chk_period(input string tag, input longint dm, input longint of,
                            input longint np, input longint nn);
    chk({tag, "_demod"},  c_demod,  dm);
    chk({tag, "_offset"}, c_offset, of);
    chk({tag, "_n_pos"},  c_np,     np);
    chk({tag, "_n_neg"},  c_nn,     nn);
  endtask

  initial begin
    set_en(1'b0);
    cd_if.adc_data_i = '0;  cd_if.adc_valid_i = 1'b0;
    cd_if.chop_i = 1'b0;    cd_if.data_hold_i = 1'b0;
    cd_if_s.adc_data_i = '0;  cd_if_s.adc_valid_i = 1'b0;
    cd_if_s.chop_i = 1'b0;    cd_if_s.data_hold_i = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_demod",  cd_if.demod_o,  0);
    chk("rst_offset", cd_if.offset_o, 0);
    chk("rst_n_pos",  cd_if.n_pos_o,  0);
    chk("rst_n_neg",  cd_if.n_neg_o,  0);
    chk("rst_valid",  cd_if.valid_o,  0);
    chk("rst_ovf",    cd_if.ovf_o,    0);
    chk("rst_locked", cd_if.locked_o, 0);

    // Enable with chop high: these 7777 samples must never be accepted.
    rst_n = 1'b1;
    set_en(1'b1);
    repeat (5) cyc(18'sd7777, 1'b1, 1'b1, 1'b0);
    chk("sync_unlocked", cd_if.locked_o, 0);
    half(1'b0, 10, 18'sd100, 1);       // lock edge sample held
    chk("locked", cd_if.locked_o, 1);
    half(1'b1, 10, 18'sd100, 0);
    chk("no_valid_prelock", vcnt, 0);

    // Constant +100, 10/10 periods.
    half(1'b0, 10, 18'sd100, 0);
    chk_period("first", -100, 1900, 9, 10);
    chk("first_valid_cnt", vcnt, 1);
    chk("first_valid_lat", first_v - lock_cyc, 20);
    chk("valid_one_cycle", cd_if.valid_o, 0);
    half(1'b1, 10, 18'sd100, 0);

    // +50/-50 with two hold samples at the start of each half.
    half(1'b0, 10, 18'sd50, 2);
    chk_period("const", 0, 2000, 10, 10);
    chk("const_valid_cnt", vcnt, 2);
    chk("const_gap", gap, 20);
    half(1'b1, 10, -18'sd50, 2);

    // Enable dropped for one slot mid positive half.
    half(1'b0, 5, 18'sd100, 0);
    chk_period("hold", 800, 0, 8, 8);
    chk("hold_valid_cnt", vcnt, 3);
    chk("hold_gap", gap, 20);
    set_en(1'b0);
    cyc(18'sd100, 1'b1, 1'b0, 1'b0);
    chk("dis_locked", cd_if.locked_o, 0);
    chk("dis_ovf",    cd_if.ovf_o,    0);
    chk("dis_ovf_s",  cd_if_s.ovf_o,  0);
    chk("dis_demod_held",  cd_if.demod_o, 800);
    chk("dis_n_pos_held",  cd_if.n_pos_o, 8);
    set_en(1'b1);
    half(1'b0, 4, 18'sd100, 0);
    half(1'b1, 10, 18'sd100, 0);
    chk("resync_unlocked", cd_if.locked_o, 0);
    half(1'b0, 10, 18'sd100, 1);
    chk("relocked", cd_if.locked_o, 1);
    chk("dis_no_valid", vcnt, 3);
    half(1'b1, 10, 18'sd100, 0);

    // 20-sample positive half: the CNT_W=4 instance saturates at 15.
    half(1'b0, 20, 18'sd100, 0);
    chk_period("relock", -100, 1900, 9, 10);
    chk("relock_valid_cnt", vcnt, 4);
    half(1'b1, 10, 18'sd100, 0);

    // Full-scale negative samples over a 100-slot positive half.
    half(1'b0, 100, NEG_FS, 0);
    chk_period("long", 1000, 3000, 20, 10);
    chk("sat_n_pos",  s_np,     15);
    chk("sat_n_neg",  s_nn,     10);
    chk("sat_demod",  s_demod,  500);
    chk("sat_offset", s_offset, 2500);
    chk("sat_ovf",    cd_if_s.ovf_o, 1);
    chk("wide_ovf",   cd_if.ovf_o,   0);
    half(1'b1, 10, 18'sd0, 0);
    cyc(18'sd0, 1'b1, 1'b0, 1'b0);
    chk("fs_valid", cd_if.valid_o, 1);
    chk_period("fs", -13107200, -13107200, 100, 10);
    chk("sat_ovf_sticky", cd_if_s.ovf_o, 1);
    cyc(18'sd0, 1'b1, 1'b0, 1'b0);
    chk("fs_valid_drop", cd_if.valid_o, 0);
    chk("valid_consec", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
